fetch_unit: RTL and testbench

//  Instruction fetch stage feeding decode: owns the fetch PC and issues word reads to instruction memory over a req/ready + rvalid handshake.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the instruction fetch stage
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and decode handshakes of the fetch stage
interface fetch_unit_if #(parameter int n = 32);

    logic         imem_req;
    logic [n-1:0] imem_addr;
    logic         imem_ready;
    logic         imem_rvalid;
    logic [n-1:0] imem_rdata;
    logic         instr_valid;
    logic [n-1:0] instr;
    logic [n-1:0] instr_pc;
    logic         instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_rvalid, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_rvalid, imem_rdata, instr_ready
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// rtl/fetch_unit_fifo.sv - prefetch buffer holding fetched words with their PCs
module fetch_fifo #(
    parameter int n     = 32,
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [n-1:0]  i_pc,
    input  logic [n-1:0]  i_word,
    output logic [CW-1:0] o_count,
    output logic [n-1:0]  o_head_pc,
    output logic [n-1:0]  o_head_word
);

    logic [n-1:0]  r_pc   [DEPTH];
    logic [n-1:0]  r_word [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // popping an empty buffer is a no-op
    assign w_pop = pop && (r_count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_word[i] <= '0;
            end
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_pc[r_wr]   <= i_pc;
                r_word[r_wr] <= i_word;
                r_wr         <= ptr_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            if (push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_count     = r_count;
    assign o_head_pc   = r_pc[r_rd];
    assign o_head_word = r_word[r_rd];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, single-outstanding imem request FSM and prefetch buffer
// Optional FETCH_MISALIGN_CHECK_EN: flags misaligned redirects and halts fetch until reset.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int           n        = 32,
    parameter int           DEPTH    = 2,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         redirect,
    input  logic [n-1:0] redirect_addr,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic         fetch_misalign,
`endif
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  r_state;
    fetch_state_t  w_next;
    logic [n-1:0]  r_pc;
    logic [n-1:0]  r_req_pc;
    logic [CW-1:0] w_count;
    logic [n-1:0]  w_head_pc;
    logic [n-1:0]  w_head_word;
    logic          w_req;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_halt;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (redirect && (redirect_addr[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign w_halt         = r_misalign;
    assign fetch_misalign = r_misalign;
`else
    assign w_halt = 1'b0;
`endif

    // a free buffer slot is reserved before issuing, so a response can always be pushed
    assign w_req    = (r_state == FETCH) && (w_count < CW'(DEPTH)) && !redirect && !reset && !w_halt;
    assign w_accept = w_req && bus.imem_ready;
    assign w_push   = (r_state == WAIT) && bus.imem_rvalid && !redirect;

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = (w_count != '0) && !reset;
    assign bus.instr       = w_head_word;
    assign bus.instr_pc    = w_head_pc;
    assign w_pop           = bus.instr_valid && bus.instr_ready;

    // a redirect with no response this cycle leaves one stale response to drain in DROP
    always_comb begin
        w_next = r_state;
        if (redirect) begin
            if (bus.imem_rvalid) begin
                w_next = FETCH;
            end else if (r_state != FETCH) begin
                w_next = DROP;
            end
        end else begin
            case (r_state)
                FETCH:   if (w_accept)        w_next = WAIT;
                WAIT:    if (bus.imem_rvalid) w_next = FETCH;
                DROP:    if (bus.imem_rvalid) w_next = FETCH;
                default:                      w_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            r_state <= w_next;
            if (redirect) begin
                r_pc <= redirect_addr;
            end else if (w_accept) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + n'(PC_STEP);
            end
        end
    end

    fetch_fifo #(
        .n     (n),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush       (redirect),
        .push        (w_push),
        .pop         (w_pop),
        .i_pc        (r_req_pc),
        .i_word      (bus.imem_rdata),
        .o_count     (w_count),
        .o_head_pc   (w_head_pc),
        .o_head_word (w_head_word)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a behavioural fetch/decode model
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    fetch_unit_if #(.n(32)) bus ();

    fetch_unit #(
        .n        (32),
        .DEPTH    (2),
        .RESET_PC (RST_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_addr  (redirect_addr),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .bus            (bus)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mem_lat = 1;

    logic [31:0] acc_q[$];
    int          acc_cyc[$];
    logic [31:0] con_q[$];
    int          con_cyc[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] qa(input int i);
        return (i < acc_q.size()) ? acc_q[i] : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] qac(input int i);
        return (i < acc_cyc.size()) ? acc_cyc[i] : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] qc(input int i);
        return (i < con_q.size()) ? con_q[i] : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] qcc(input int i);
        return (i < con_cyc.size()) ? con_cyc[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instruction memory: every accepted request is answered mem_lat cycles later.
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clock);
            #1;
            bus.imem_rvalid = 1'b0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = memfn(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
        end
    end

    // Model: decode must see consecutive PCs from the last reset/redirect target,
    // requests walk the same way, and at most one request is ever unanswered.
    logic [31:0] m_exp_pc;
    logic [31:0] m_exp_req;
    int          m_out;
    bit          m_hold;
    logic [31:0] m_hold_instr;
    logic [31:0] m_hold_pc;
    bit          m_mis;

    initial begin
        m_exp_pc = RST_PC; m_exp_req = RST_PC; m_out = 0; m_hold = 0; m_mis = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                chk_eq("req_in_reset", bus.imem_req, 1'b0);
                chk_eq("valid_in_reset", bus.instr_valid, 1'b0);
                m_exp_pc = RST_PC; m_exp_req = RST_PC; m_out = 0; m_hold = 0; m_mis = 0;
            end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
                chk_eq("misalign_flag", fetch_misalign, m_mis);
`endif
                if (m_mis) chk_eq("req_halted", bus.imem_req, 1'b0);
                if (m_hold) begin
                    chk_eq("hold_instr", bus.instr, m_hold_instr);
                    chk_eq("hold_pc", bus.instr_pc, m_hold_pc);
                end
                if (redirect) chk_eq("req_in_redirect", bus.imem_req, 1'b0);
                if (bus.imem_req) begin
                    chk_eq("one_outstanding", m_out, 0);
                    chk_eq("req_addr", bus.imem_addr, m_exp_req);
                end
                if (bus.instr_valid) chk_eq("instr_word", bus.instr, memfn(bus.instr_pc));
                if (bus.instr_valid && bus.instr_ready) begin
                    chk_eq("instr_pc", bus.instr_pc, m_exp_pc);
                    con_q.push_back(bus.instr_pc);
                    con_cyc.push_back(cyc);
                    m_exp_pc = bus.instr_pc + 32'd4;
                end
                if (bus.imem_rvalid && m_out > 0) m_out--;
                if (bus.imem_req && bus.imem_ready) begin
                    m_out++;
                    acc_q.push_back(bus.imem_addr);
                    acc_cyc.push_back(cyc);
                    pend_addr.push_back(bus.imem_addr);
                    pend_due.push_back(cyc + mem_lat);
                    m_exp_req = bus.imem_addr + 32'd4;
                end
                if (redirect) begin
                    m_exp_pc  = redirect_addr;
                    m_exp_req = redirect_addr;
                    if (redirect_addr[1:0] != 2'b00) m_mis = 1;
                end
                m_hold       = bus.instr_valid && !bus.instr_ready && !redirect;
                m_hold_instr = bus.instr;
                m_hold_pc    = bus.instr_pc;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_logs();
        acc_q.delete(); acc_cyc.delete(); con_q.delete(); con_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_acc(input int k);
        int t = 0;
        while (acc_q.size() < k && t < 200) begin tick(); t++; end
        chk_eq("wait_acc", acc_q.size(), k);
    endtask

    task automatic wait_con(input int k);
        int t = 0;
        while (con_q.size() < k && t < 200) begin tick(); t++; end
        chk_eq("wait_con", con_q.size(), k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1);
    end

    int rc;

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_addr = '0;
        bus.instr_ready = 1'b1; bus.imem_ready = 1'b0;
        tick();
        reset = 1'b0;
        clear_logs();

        // T1: reset values, stalled memory, then straight-line fetch 0,4,8 at 1 per 2 cycles
        @(negedge clock);
        chk_eq("rst_instr", bus.instr, 32'h0);
        chk_eq("rst_instr_pc", bus.instr_pc, 32'h0);
        chk_eq("rst_valid", bus.instr_valid, 1'b0);
        chk_eq("rst_req", bus.imem_req, 1'b1);
        chk_eq("rst_addr", bus.imem_addr, 32'h0);
        repeat (2) tick();
        bus.imem_ready = 1'b1;
        wait_con(3);
        chk_eq("t1_acc0", qa(0), 32'h0);
        chk_eq("t1_acc1", qa(1), 32'h4);
        chk_eq("t1_acc2", qa(2), 32'h8);
        chk_eq("t1_con0", qc(0), 32'h0);
        chk_eq("t1_con1", qc(1), 32'h4);
        chk_eq("t1_con2", qc(2), 32'h8);
        chk_eq("t1_rate", qcc(1) - qcc(0), 32'd2);

        // T2: decode stalled, buffer fills with two entries, then drains and fetch resumes at 8
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        chk_eq("t2_acc_cnt", acc_q.size(), 2);
        chk_eq("t2_acc1", qa(1), 32'h4);
        @(negedge clock);
        chk_eq("t2_req_full", bus.imem_req, 1'b0);
        chk_eq("t2_valid", bus.instr_valid, 1'b1);
        chk_eq("t2_head_pc", bus.instr_pc, 32'h0);
        chk_eq("t2_head_word", bus.instr, 32'h5A5A_C3C3);
        tick();
        bus.instr_ready = 1'b1;
        wait_con(3);
        chk_eq("t2_con0", qc(0), 32'h0);
        chk_eq("t2_con1", qc(1), 32'h4);
        chk_eq("t2_con2", qc(2), 32'h8);
        chk_eq("t2_acc2", qa(2), 32'h8);

        // T3: redirect while a slow response is outstanding; it must be dropped
        mem_lat = 3;
        do_reset();
        wait_acc(1);
        redirect = 1'b1; redirect_addr = 32'h100;
        tick();
        redirect = 1'b0;
        wait_con(2);
        chk_eq("t3_con0", qc(0), 32'h100);
        chk_eq("t3_con1", qc(1), 32'h104);
        chk_eq("t3_acc1", qa(1), 32'h100);
        chk_eq("t3_acc_gap", qac(1) - qac(0), 32'd4);

        // T4: redirect in the same cycle as the response
        mem_lat = 1;
        do_reset();
        wait_acc(1);
        redirect = 1'b1; redirect_addr = 32'h200;
        rc = cyc;
        tick();
        redirect = 1'b0;
        wait_con(1);
        chk_eq("t4_acc1", qa(1), 32'h200);
        chk_eq("t4_acc_cyc", qac(1), rc + 1);
        chk_eq("t4_con0", qc(0), 32'h200);

        // T5: reset while waiting on the request for 8; its late response must be ignored
        mem_lat = 2;
        do_reset();
        wait_acc(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_logs();
        rc = cyc;
        wait_con(1);
        chk_eq("t5_con0", qc(0), 32'h0);
        chk_eq("t5_acc0", qa(0), 32'h0);
        chk_eq("t5_acc_cyc", qac(0), rc);
        chk_eq("t5_con_cyc", qcc(0), rc + 3);

`ifdef FETCH_MISALIGN_CHECK_EN
        // T6: misaligned redirect halts fetch until reset
        mem_lat = 1;
        do_reset();
        redirect = 1'b1; redirect_addr = 32'h102;
        tick();
        redirect = 1'b0;
        @(negedge clock);
        chk_eq("t6_misalign", fetch_misalign, 1'b1);
        chk_eq("t6_req", bus.imem_req, 1'b0);
        repeat (6) tick();
        chk_eq("t6_no_acc", acc_q.size(), 0);
        do_reset();
        @(negedge clock);
        chk_eq("t6_cleared", fetch_misalign, 1'b0);
        wait_con(1);
        chk_eq("t6_con0", qc(0), RST_PC);
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
